// File: rtl/local_network_interface.sv
// Mesh node network interface on the router LOCAL port: injection FIFO with
// routing sign bits toward the router, 2-entry ejection skid buffer toward the PE.
module local_network_interface #(
    parameter int DATA_WIDTH = 512,
    parameter int MESH_SIDE  = 3,
    parameter int X_COORD    = 1,
    parameter int Y_COORD    = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = (MESH_SIDE > 1) ? $clog2(MESH_SIDE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [CW-1:0]         req_dest_x,
    input  logic [CW-1:0]         req_dest_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         out_dest_x,
    output logic [CW-1:0]         out_dest_y,
    output logic                  out_s_delta_x,
    output logic                  out_s_delta_y,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CW-1:0]         in_dest_x,
    input  logic [CW-1:0]         in_dest_y,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  misroute_err,
    output logic [15:0]           tx_count,
    output logic [15:0]           rx_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] X_C = CW'(X_COORD);
    localparam logic [CW-1:0] Y_C = CW'(Y_COORD);

    logic [DATA_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
    logic [CW-1:0]         fifo_dx_r   [FIFO_DEPTH];
    logic [CW-1:0]         fifo_dy_r   [FIFO_DEPTH];
    logic                  fifo_sx_r   [FIFO_DEPTH];
    logic                  fifo_sy_r   [FIFO_DEPTH];

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] wr_ptr_nxt_s;
    logic [AW:0] rd_ptr_nxt_s;
    logic        push_s;
    logic        pop_s;
    logic        full_nxt_s;
    logic        empty_nxt_s;
    logic        req_ready_r;
    logic        out_valid_r;
    logic [15:0] tx_count_r;

    logic [DATA_WIDTH-1:0] skid0_r;
    logic [DATA_WIDTH-1:0] skid1_r;
    logic [1:0]            skid_occ_r;
    logic [1:0]            skid_occ_nxt_s;
    logic                  accept_s;
    logic                  drain_s;
    logic                  misrouted_s;
    logic                  in_ready_r;
    logic                  rx_valid_r;
    logic                  misroute_r;
    logic [15:0]           rx_count_r;

    // Injection FIFO pointer arithmetic and next-cycle full/empty status
    always_comb begin
        push_s       = req_valid && req_ready_r;
        pop_s        = out_valid_r && out_ready;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        full_nxt_s  = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                      (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    end

    // Injection FIFO storage, pointers, handshake flags and tx counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            req_ready_r <= 1'b0;
            out_valid_r <= 1'b0;
            tx_count_r  <= 16'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_r[i] <= '0;
                fifo_dx_r[i]   <= '0;
                fifo_dy_r[i]   <= '0;
                fifo_sx_r[i]   <= 1'b0;
                fifo_sy_r[i]   <= 1'b0;
            end
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            req_ready_r <= !full_nxt_s;
            out_valid_r <= !empty_nxt_s;
            if (pop_s) begin
                tx_count_r <= tx_count_r + 16'd1;
            end
            // Routing sign bits are fixed at push so the head never re-derives them
            if (push_s) begin
                fifo_data_r[wr_ptr_r[AW-1:0]] <= req_data;
                fifo_dx_r[wr_ptr_r[AW-1:0]]   <= req_dest_x;
                fifo_dy_r[wr_ptr_r[AW-1:0]]   <= req_dest_y;
                fifo_sx_r[wr_ptr_r[AW-1:0]]   <= (req_dest_x < X_C);
                fifo_sy_r[wr_ptr_r[AW-1:0]]   <= (req_dest_y < Y_C);
            end
        end
    end

    // Ejection skid buffer occupancy update
    always_comb begin
        accept_s    = in_valid && in_ready_r;
        drain_s     = rx_valid_r && rx_ready;
        misrouted_s = (in_dest_x != X_C) || (in_dest_y != Y_C);
        case ({accept_s, drain_s})
            2'b10:   skid_occ_nxt_s = skid_occ_r + 2'd1;
            2'b01:   skid_occ_nxt_s = skid_occ_r - 2'd1;
            default: skid_occ_nxt_s = skid_occ_r;
        endcase
    end

    // Ejection skid buffer storage, flags, misroute flag and rx counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            skid0_r    <= '0;
            skid1_r    <= '0;
            skid_occ_r <= 2'd0;
            in_ready_r <= 1'b0;
            rx_valid_r <= 1'b0;
            misroute_r <= 1'b0;
            rx_count_r <= 16'd0;
        end else begin
            skid_occ_r <= skid_occ_nxt_s;
            in_ready_r <= (skid_occ_nxt_s < 2'd2);
            rx_valid_r <= (skid_occ_nxt_s != 2'd0);
            if (accept_s) begin
                rx_count_r <= rx_count_r + 16'd1;
                if (misrouted_s) begin
                    misroute_r <= 1'b1;
                end
            end
            // skid0 always holds the oldest entry
            if (accept_s && ((skid_occ_r == 2'd0) || ((skid_occ_r == 2'd1) && drain_s))) begin
                skid0_r <= in_data;
            end else if (drain_s && (skid_occ_r == 2'd2)) begin
                skid0_r <= skid1_r;
            end
            if (accept_s && (skid_occ_r == 2'd1) && !drain_s) begin
                skid1_r <= in_data;
            end
        end
    end

    assign req_ready     = req_ready_r;
    assign out_valid     = out_valid_r;
    assign out_data      = fifo_data_r[rd_ptr_r[AW-1:0]];
    assign out_dest_x    = fifo_dx_r[rd_ptr_r[AW-1:0]];
    assign out_dest_y    = fifo_dy_r[rd_ptr_r[AW-1:0]];
    assign out_s_delta_x = fifo_sx_r[rd_ptr_r[AW-1:0]];
    assign out_s_delta_y = fifo_sy_r[rd_ptr_r[AW-1:0]];
    assign in_ready      = in_ready_r;
    assign rx_valid      = rx_valid_r;
    assign rx_data       = skid0_r;
    assign misroute_err  = misroute_r;
    assign tx_count      = tx_count_r;
    assign rx_count      = rx_count_r;

endmodule

// File: tb/tb_local_network_interface.sv
// Directed bench for local_network_interface at node (1,1) of a 3x3 mesh.
module tb_local_network_interface;

    localparam int DW = 512;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic [1:0]    req_dest_x;
    logic [1:0]    req_dest_y;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_dest_x;
    logic [1:0]    out_dest_y;
    logic          out_s_delta_x;
    logic          out_s_delta_y;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest_x;
    logic [1:0]    in_dest_y;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          misroute_err;
    logic [15:0]   tx_count;
    logic [15:0]   rx_count;

    int checks;
    int fails;

    local_network_interface #(
        .DATA_WIDTH(DW), .MESH_SIDE(3), .X_COORD(1), .Y_COORD(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
        .out_s_delta_x(out_s_delta_x), .out_s_delta_y(out_s_delta_y),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_dest_x(in_dest_x), .in_dest_y(in_dest_y),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .misroute_err(misroute_err), .tx_count(tx_count), .rx_count(rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks += 8;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %0b exp 0", rx_valid); end
        if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %0b exp 0", req_ready); end
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        if (tx_count !== 16'd0) begin fails++; $display("FAIL reset_tx_count got %0d exp 0", tx_count); end
        if (rx_count !== 16'd0) begin fails++; $display("FAIL reset_rx_count got %0d exp 0", rx_count); end
        if (misroute_err !== 1'b0) begin fails++; $display("FAIL reset_misroute got %0b exp 0", misroute_err); end
        if (out_data !== '0 || rx_data !== '0) begin fails++; $display("FAIL reset_data got %0h/%0h exp 0", out_data, rx_data); end
        rst = 1'b1;
        tick();
        checks += 2;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL release_req_ready got %0b exp 1", req_ready); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_inject();
        req_valid = 1'b1; req_data = 512'hA1; req_dest_x = 2'd0; req_dest_y = 2'd2;
        out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        checks += 4;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL inject_valid got %0b exp 1", out_valid); end
        if (out_data !== 512'hA1) begin fails++; $display("FAIL inject_data got %0h exp a1", out_data); end
        if ({out_dest_x, out_dest_y} !== 4'b0010) begin fails++; $display("FAIL inject_dest got %0b exp 0010", {out_dest_x, out_dest_y}); end
        if ({out_s_delta_x, out_s_delta_y} !== 2'b10) begin fails++; $display("FAIL inject_sdelta got %0b exp 10", {out_s_delta_x, out_s_delta_y}); end
        tick();
        checks += 2;
        if (tx_count !== 16'd1) begin fails++; $display("FAIL inject_tx_count got %0d exp 1", tx_count); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL inject_drained got %0b exp 0", out_valid); end
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] exp_d;
        out_ready = 1'b0;
        req_dest_x = 2'd2; req_dest_y = 2'd2;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_data = 512'hB0 + DW'(i);
            tick();
            if (i == 3) begin
                checks++;
                if (req_ready !== 1'b0) begin fails++; $display("FAIL full_req_ready got %0b exp 0", req_ready); end
            end
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 512'hB0 + DW'(i);
            checks += 2;
            if (out_valid !== 1'b1 || out_data !== exp_d) begin
                fails++; $display("FAIL drain_%0d got v=%0b d=%0h exp v=1 d=%0h", i, out_valid, out_data, exp_d);
            end
            if ({out_s_delta_x, out_s_delta_y} !== 2'b00) begin fails++; $display("FAIL drain_sdelta_%0d got %0b exp 00", i, {out_s_delta_x, out_s_delta_y}); end
            tick();
            if (i == 0) begin
                checks++;
                if (req_ready !== 1'b1) begin fails++; $display("FAIL unfull_req_ready got %0b exp 1", req_ready); end
            end
        end
        checks += 2;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL full_empty got %0b exp 0", out_valid); end
        if (tx_count !== 16'd5) begin fails++; $display("FAIL full_tx_count got %0d exp 5", tx_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        req_dest_x = 2'd1; req_dest_y = 2'd0;
        req_valid = 1'b1; req_data = 512'hC0; tick();
        req_data = 512'hC1; tick();
        req_data = 512'hC2; req_dest_x = 2'd1; req_dest_y = 2'd1;
        out_ready = 1'b1;
        tick();
        req_valid = 1'b0; out_ready = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1 || out_data !== 512'hC1) begin fails++; $display("FAIL pushpop_head got v=%0b d=%0h exp v=1 d=c1", out_valid, out_data); end
        if ({out_s_delta_x, out_s_delta_y} !== 2'b01) begin fails++; $display("FAIL pushpop_sdelta got %0b exp 01", {out_s_delta_x, out_s_delta_y}); end
        if (req_ready !== 1'b1) begin fails++; $display("FAIL pushpop_req_ready got %0b exp 1", req_ready); end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_valid !== 1'b1 || out_data !== 512'hC2) begin fails++; $display("FAIL pushpop_second got v=%0b d=%0h exp v=1 d=c2", out_valid, out_data); end
        if ({out_s_delta_x, out_s_delta_y} !== 2'b00) begin fails++; $display("FAIL pushpop_self_sdelta got %0b exp 00", {out_s_delta_x, out_s_delta_y}); end
        tick();
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL pushpop_empty got %0b exp 0", out_valid); end
        if (tx_count !== 16'd8) begin fails++; $display("FAIL pushpop_tx_count got %0d exp 8", tx_count); end
    endtask

    task automatic test_eject();
        rx_ready = 1'b0;
        in_dest_x = 2'd1; in_dest_y = 2'd1;
        in_valid = 1'b1; in_data = 512'hD0; tick();
        in_data = 512'hD1; tick();
        in_data = 512'hD2;
        checks += 3;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL eject_full_in_ready got %0b exp 0", in_ready); end
        if (rx_valid !== 1'b1 || rx_data !== 512'hD0) begin fails++; $display("FAIL eject_head got v=%0b d=%0h exp v=1 d=d0", rx_valid, rx_data); end
        if (rx_count !== 16'd2) begin fails++; $display("FAIL eject_count2 got %0d exp 2", rx_count); end
        tick();
        checks++;
        if (rx_count !== 16'd2) begin fails++; $display("FAIL eject_refused got %0d exp 2", rx_count); end
        rx_ready = 1'b1;
        tick();
        checks += 2;
        if (rx_data !== 512'hD1) begin fails++; $display("FAIL eject_second got %0h exp d1", rx_data); end
        if (in_ready !== 1'b1) begin fails++; $display("FAIL eject_reopen got %0b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (rx_valid !== 1'b1 || rx_data !== 512'hD2) begin fails++; $display("FAIL eject_third got v=%0b d=%0h exp v=1 d=d2", rx_valid, rx_data); end
        if (rx_count !== 16'd3) begin fails++; $display("FAIL eject_count3 got %0d exp 3", rx_count); end
        tick();
        checks += 2;
        if (rx_valid !== 1'b0) begin fails++; $display("FAIL eject_empty got %0b exp 0", rx_valid); end
        if (misroute_err !== 1'b0) begin fails++; $display("FAIL eject_no_misroute got %0b exp 0", misroute_err); end
    endtask

    task automatic test_misroute();
        rx_ready = 1'b1;
        in_valid = 1'b1; in_data = 512'hE0; in_dest_x = 2'd2; in_dest_y = 2'd0;
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (rx_valid !== 1'b1 || rx_data !== 512'hE0) begin fails++; $display("FAIL misroute_deliver got v=%0b d=%0h exp v=1 d=e0", rx_valid, rx_data); end
        if (misroute_err !== 1'b1) begin fails++; $display("FAIL misroute_set got %0b exp 1", misroute_err); end
        tick();
        tick();
        tick();
        checks++;
        if (misroute_err !== 1'b1) begin fails++; $display("FAIL misroute_sticky got %0b exp 1", misroute_err); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        req_dest_x = 2'd0; req_dest_y = 2'd0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_data = 512'hF0 + DW'(i); tick();
        end
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL midflight_loaded got %0b exp 1", out_valid); end
        rst = 1'b0;
        tick();
        checks += 5;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL midflight_out_valid got %0b exp 0", out_valid); end
        if (tx_count !== 16'd0 || rx_count !== 16'd0) begin fails++; $display("FAIL midflight_counts got %0d/%0d exp 0/0", tx_count, rx_count); end
        if (misroute_err !== 1'b0) begin fails++; $display("FAIL midflight_misroute got %0b exp 0", misroute_err); end
        if (req_ready !== 1'b0) begin fails++; $display("FAIL midflight_req_ready got %0b exp 0", req_ready); end
        if (out_data !== '0) begin fails++; $display("FAIL midflight_out_data got %0h exp 0", out_data); end
        rst = 1'b1;
        tick();
        checks += 2;
        if (req_ready !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL midflight_release got %0b/%0b exp 1/1", req_ready, in_ready); end
        if (out_valid !== 1'b0) begin fails++; $display("FAIL midflight_empty got %0b exp 0", out_valid); end
        req_valid = 1'b1; req_data = 512'h77; req_dest_x = 2'd2; req_dest_y = 2'd1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 512'h77) begin fails++; $display("FAIL midflight_fresh got v=%0b d=%0h exp v=1 d=77", out_valid, out_data); end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b0;
        req_valid = 1'b0; req_data = '0; req_dest_x = 2'd0; req_dest_y = 2'd0;
        out_ready = 1'b0;
        in_valid = 1'b0; in_data = '0; in_dest_x = 2'd0; in_dest_y = 2'd0;
        rx_ready = 1'b0;
        test_reset();
        test_inject();
        test_fifo_full();
        test_push_pop();
        test_eject();
        test_misroute();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
